// File: rtl/faux_hd_transport_tx.sv
// Device-side transport transmit stage: latches a device-to-host FIS request from the
// command layer and serializes it as 32-bit dwords into the link layer write port.
module faux_hd_transport_tx #(
    parameter int DATA_DWORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    output logic        transport_layer_ready,
    input  logic        send_reg_stb,
    input  logic        send_dev_bits_stb,
    input  logic        send_pio_stb,
    input  logic        send_dma_act_stb,
    input  logic        send_data_stb,
    input  logic        d2h_interrupt,
    input  logic        d2h_notification,
    input  logic [7:0]  d2h_status,
    input  logic [7:0]  d2h_error,
    input  logic [3:0]  d2h_port_mult,
    input  logic [7:0]  d2h_device,
    input  logic [47:0] d2h_lba,
    input  logic [15:0] d2h_sector_count,
    input  logic [15:0] pio_transfer_count,
    input  logic        pio_direction,
    input  logic [7:0]  pio_e_status,
    output logic        src_strobe,
    input  logic [31:0] src_data,
    input  logic        ll_ready,
    output logic        ll_write_start,
    output logic [23:0] ll_write_size,
    output logic        ll_write_strobe,
    output logic [31:0] ll_write_data,
    input  logic        ll_write_hold,
    input  logic        ll_write_finished,
    input  logic        ll_xmit_error,
    output logic        xmit_error
);

    typedef enum logic [1:0] {IDLE, START, SEND, WAIT_FIN} state_t;
    typedef enum logic [2:0] {FIS_REG, FIS_DEV_BITS, FIS_PIO, FIS_DMA_ACT, FIS_DATA} fis_t;

    localparam logic [13:0] DATA_LEN = 14'(DATA_DWORDS + 1);

    state_t      state_reg, state_next;
    fis_t        fis_reg, fis_next;
    logic [13:0] index_reg, index_next;
    logic        xmit_error_reg, xmit_error_next;

    logic        interrupt_reg, notification_reg, direction_reg;
    logic [7:0]  status_reg, error_reg, device_reg, e_status_reg;
    logic [3:0]  port_mult_reg;
    logic [47:0] lba_reg;
    logic [15:0] sector_count_reg, xfer_count_reg;

    logic        any_send;
    logic        accept;
    logic [13:0] frame_len;
    logic [31:0] header_dword;
    logic        payload_slot;

    assign any_send = send_reg_stb | send_dev_bits_stb | send_pio_stb
                    | send_dma_act_stb | send_data_stb;
    assign transport_layer_ready = (state_reg == IDLE) && ll_ready;
    assign accept = transport_layer_ready && any_send;
    assign xmit_error = xmit_error_reg;
    assign payload_slot = (fis_reg == FIS_DATA) && (index_reg != 14'd0);

    // Fixed priority when several send strobes coincide; the losers are dropped.
    always_comb begin
        fis_next = fis_reg;
        if (send_reg_stb)           fis_next = FIS_REG;
        else if (send_dev_bits_stb) fis_next = FIS_DEV_BITS;
        else if (send_pio_stb)      fis_next = FIS_PIO;
        else if (send_dma_act_stb)  fis_next = FIS_DMA_ACT;
        else if (send_data_stb)     fis_next = FIS_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            fis_reg          <= FIS_REG;
            index_reg        <= '0;
            xmit_error_reg   <= 1'b0;
            interrupt_reg    <= 1'b0;
            notification_reg <= 1'b0;
            direction_reg    <= 1'b0;
            status_reg       <= '0;
            error_reg        <= '0;
            device_reg       <= '0;
            e_status_reg     <= '0;
            port_mult_reg    <= '0;
            lba_reg          <= '0;
            sector_count_reg <= '0;
            xfer_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            index_reg      <= index_next;
            xmit_error_reg <= xmit_error_next;
            if (accept) begin
                fis_reg          <= fis_next;
                interrupt_reg    <= d2h_interrupt;
                notification_reg <= d2h_notification;
                direction_reg    <= pio_direction;
                status_reg       <= d2h_status;
                error_reg        <= d2h_error;
                device_reg       <= d2h_device;
                e_status_reg     <= pio_e_status;
                port_mult_reg    <= d2h_port_mult;
                lba_reg          <= d2h_lba;
                sector_count_reg <= d2h_sector_count;
                xfer_count_reg   <= pio_transfer_count;
            end
        end
    end

    always_comb begin
        case (fis_reg)
            FIS_REG:      frame_len = 14'd5;
            FIS_DEV_BITS: frame_len = 14'd2;
            FIS_PIO:      frame_len = 14'd5;
            FIS_DMA_ACT:  frame_len = 14'd1;
            FIS_DATA:     frame_len = DATA_LEN;
            default:      frame_len = 14'd1;
        endcase
    end

    // Non-payload dwords; only the low index bits matter since headers are at most 5 dwords.
    always_comb begin
        header_dword = '0;
        case (fis_reg)
            FIS_REG: begin
                case (index_reg[2:0])
                    3'd0:    header_dword = {error_reg, status_reg, 1'b0, interrupt_reg,
                                             2'b00, port_mult_reg, 8'h34};
                    3'd1:    header_dword = {device_reg, lba_reg[23:0]};
                    3'd2:    header_dword = {8'h00, lba_reg[47:24]};
                    3'd3:    header_dword = {16'h0000, sector_count_reg};
                    default: header_dword = '0;
                endcase
            end
            FIS_DEV_BITS: begin
                if (index_reg[2:0] == 3'd0)
                    header_dword = {error_reg, 1'b0, status_reg[6:4], 1'b0, status_reg[2:0],
                                    notification_reg, interrupt_reg, 2'b00, port_mult_reg, 8'hA1};
            end
            FIS_PIO: begin
                case (index_reg[2:0])
                    3'd0:    header_dword = {error_reg, status_reg, 1'b0, interrupt_reg,
                                             direction_reg, 1'b0, port_mult_reg, 8'h5F};
                    3'd1:    header_dword = {device_reg, lba_reg[23:0]};
                    3'd2:    header_dword = {8'h00, lba_reg[47:24]};
                    3'd3:    header_dword = {e_status_reg, 8'h00, sector_count_reg};
                    3'd4:    header_dword = {16'h0000, xfer_count_reg};
                    default: header_dword = '0;
                endcase
            end
            FIS_DMA_ACT: header_dword = {20'h00000, port_mult_reg, 8'h39};
            FIS_DATA:    header_dword = {20'h00000, port_mult_reg, 8'h46};
            default:     header_dword = '0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        index_next      = index_reg;
        xmit_error_next = 1'b0;
        ll_write_start  = 1'b0;
        ll_write_size   = '0;
        ll_write_strobe = 1'b0;
        ll_write_data   = '0;
        src_strobe      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                ll_write_start = 1'b1;
                ll_write_size  = {10'd0, frame_len};
                index_next     = '0;
                state_next     = SEND;
            end
            SEND: begin
                if (!ll_write_hold) begin
                    ll_write_strobe = 1'b1;
                    ll_write_data   = payload_slot ? src_data : header_dword;
                    src_strobe      = payload_slot;
                    index_next      = index_reg + 14'd1;
                    if (index_reg == frame_len - 14'd1) state_next = WAIT_FIN;
                end
            end
            WAIT_FIN: begin
                if (ll_write_finished) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A link failure overrides everything: nothing is strobed and the source is not consumed.
        if (state_reg != IDLE && ll_xmit_error) begin
            state_next      = IDLE;
            xmit_error_next = 1'b1;
            ll_write_strobe = 1'b0;
            ll_write_data   = '0;
            src_strobe      = 1'b0;
        end
    end

endmodule

// File: tb/tb_faux_hd_transport_tx.sv
// Scoreboard bench for faux_hd_transport_tx: a byte-level FIS model fills expectation
// queues at issue time, and a negedge monitor drains them as the link side sees dwords.
module tb_faux_hd_transport_tx;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    logic transport_layer_ready;
    logic send_reg_stb, send_dev_bits_stb, send_pio_stb, send_dma_act_stb, send_data_stb;
    logic d2h_interrupt, d2h_notification;
    logic [7:0] d2h_status, d2h_error, d2h_device, pio_e_status;
    logic [3:0] d2h_port_mult;
    logic [47:0] d2h_lba;
    logic [15:0] d2h_sector_count, pio_transfer_count;
    logic pio_direction;
    logic src_strobe;
    logic [31:0] src_data;
    logic ll_ready, ll_write_start, ll_write_strobe, ll_write_hold;
    logic [23:0] ll_write_size;
    logic [31:0] ll_write_data;
    logic ll_write_finished, ll_xmit_error, xmit_error;

    always #5 clk = ~clk;

    faux_hd_transport_tx #(.DATA_DWORDS(DW)) dut (
        .clk(clk), .rst(rst), .transport_layer_ready(transport_layer_ready),
        .send_reg_stb(send_reg_stb), .send_dev_bits_stb(send_dev_bits_stb),
        .send_pio_stb(send_pio_stb), .send_dma_act_stb(send_dma_act_stb),
        .send_data_stb(send_data_stb), .d2h_interrupt(d2h_interrupt),
        .d2h_notification(d2h_notification), .d2h_status(d2h_status),
        .d2h_error(d2h_error), .d2h_port_mult(d2h_port_mult), .d2h_device(d2h_device),
        .d2h_lba(d2h_lba), .d2h_sector_count(d2h_sector_count),
        .pio_transfer_count(pio_transfer_count), .pio_direction(pio_direction),
        .pio_e_status(pio_e_status), .src_strobe(src_strobe), .src_data(src_data),
        .ll_ready(ll_ready), .ll_write_start(ll_write_start), .ll_write_size(ll_write_size),
        .ll_write_strobe(ll_write_strobe), .ll_write_data(ll_write_data),
        .ll_write_hold(ll_write_hold), .ll_write_finished(ll_write_finished),
        .ll_xmit_error(ll_xmit_error), .xmit_error(xmit_error)
    );

    typedef struct {
        logic i, n, d;
        logic [7:0] st, er, dev, es;
        logic [3:0] pm;
        logic [47:0] lba;
        logic [15:0] cnt, xfer;
    } fld_t;

    typedef struct {
        logic [31:0] data;
        logic        payload;
    } exp_t;

    exp_t exp_q[$];
    int   size_q[$];
    int   exp_xerr = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] src_cnt = 32'd0;
    logic [31:0] model_src = 32'd0;

    // Payload source: an incrementing sequence starting at A0h, advanced on each consume.
    assign src_data = 32'hA0 + src_cnt;
    always @(posedge clk) if (src_strobe) src_cnt <= src_cnt + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ll_write_start) begin
            if (size_q.size() == 0) check1("unexpected_start", ll_write_start, 1'b0);
            else check("write_size", 32'(ll_write_size), 32'(size_q.pop_front()));
        end
        if (ll_write_strobe) begin
            check1("strobe_during_hold", ll_write_hold, 1'b0);
            if (exp_q.size() == 0) check1("unexpected_strobe", ll_write_strobe, 1'b0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_data", ll_write_data, e.data);
                check1("src_strobe", src_strobe, e.payload);
                $display("dword %h src_strobe=%b", ll_write_data, src_strobe);
            end
        end else if (src_strobe) begin
            check1("src_strobe_without_write", src_strobe, 1'b0);
        end
        if (xmit_error) begin
            if (exp_xerr == 0) check1("unexpected_xmit_error", xmit_error, 1'b0);
            else exp_xerr--;
        end
    end

    // Reference model: lay the FIS out byte by byte, then pack little-endian dwords.
    function automatic void push_frame(input int t, input fld_t f);
        logic [7:0] b[$];
        int nd;
        exp_t e;
        case (t)
            0: b = '{8'h34, {1'b0, f.i, 2'b00, f.pm}, f.st, f.er,
                     f.lba[7:0], f.lba[15:8], f.lba[23:16], f.dev,
                     f.lba[31:24], f.lba[39:32], f.lba[47:40], 8'h00,
                     f.cnt[7:0], f.cnt[15:8], 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00};
            1: b = '{8'hA1, {f.n, f.i, 2'b00, f.pm}, {1'b0, f.st[6:4], 1'b0, f.st[2:0]}, f.er,
                     8'h00, 8'h00, 8'h00, 8'h00};
            2: b = '{8'h5F, {1'b0, f.i, f.d, 1'b0, f.pm}, f.st, f.er,
                     f.lba[7:0], f.lba[15:8], f.lba[23:16], f.dev,
                     f.lba[31:24], f.lba[39:32], f.lba[47:40], 8'h00,
                     f.cnt[7:0], f.cnt[15:8], 8'h00, f.es,
                     f.xfer[7:0], f.xfer[15:8], 8'h00, 8'h00};
            3: b = '{8'h39, {4'h0, f.pm}, 8'h00, 8'h00};
            default: b = '{8'h46, {4'h0, f.pm}, 8'h00, 8'h00};
        endcase
        nd = b.size() / 4;
        for (int k = 0; k < nd; k++) begin
            e.data = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
            e.payload = 1'b0;
            exp_q.push_back(e);
        end
        if (t == 4) begin
            for (int k = 0; k < DW; k++) begin
                e.data = 32'hA0 + model_src;
                e.payload = 1'b1;
                model_src = model_src + 32'd1;
                exp_q.push_back(e);
            end
            nd = nd + DW;
        end
        size_q.push_back(nd);
    endfunction

    function automatic fld_t rand_fields();
        fld_t f;
        f.i = 1'($urandom); f.n = 1'($urandom); f.d = 1'($urandom);
        f.st = 8'($urandom); f.er = 8'($urandom); f.dev = 8'($urandom); f.es = 8'($urandom);
        f.pm = 4'($urandom);
        f.lba = {16'($urandom), 32'($urandom)};
        f.cnt = 16'($urandom); f.xfer = 16'($urandom);
        return f;
    endfunction

    task automatic drive_fields(input fld_t f);
        d2h_interrupt = f.i; d2h_notification = f.n; pio_direction = f.d;
        d2h_status = f.st; d2h_error = f.er; d2h_device = f.dev; pio_e_status = f.es;
        d2h_port_mult = f.pm; d2h_lba = f.lba;
        d2h_sector_count = f.cnt; pio_transfer_count = f.xfer;
    endtask

    task automatic drive_strobes(input logic [4:0] m);
        send_reg_stb = m[0]; send_dev_bits_stb = m[1]; send_pio_stb = m[2];
        send_dma_act_stb = m[3]; send_data_stb = m[4];
    endtask

    // Called just after a rising edge with the DUT idle. hold_pct<0 means alternate-cycle hold.
    task automatic run_frame(input logic [4:0] mask, input fld_t f, input int hold_pct,
                             input int err_after, input int rst_after, input bit dma_mid);
        int t, total, sent, cyc;
        t = 0;
        while (!mask[t]) t++;
        check1("ready_idle", transport_layer_ready, 1'b1);
        drive_fields(f);
        drive_strobes(mask);
        push_frame(t, f);
        total = exp_q.size();
        $display("issue mask=%b type=%0d dwords=%0d", mask, t, total);
        @(posedge clk); #1;
        drive_strobes(5'b0);
        drive_fields(rand_fields());
        check1("ready_busy", transport_layer_ready, 1'b0);
        for (cyc = 0; cyc < 2000; cyc++) begin
            sent = total - exp_q.size();
            if (err_after >= 0 && sent >= err_after) begin
                exp_xerr++;
                ll_xmit_error = 1'b1;
                ll_write_hold = 1'b0;
                @(negedge clk);
                check1("no_strobe_on_error", ll_write_strobe, 1'b0);
                @(posedge clk); #1;
                ll_xmit_error = 1'b0;
                check1("xmit_error_pulse", xmit_error, 1'b1);
                check1("ready_after_error", transport_layer_ready, 1'b1);
                @(posedge clk); #1;
                check1("xmit_error_single", xmit_error, 1'b0);
                check("xmit_error_count", 32'(exp_xerr), 32'd0);
                exp_q.delete(); size_q.delete();
                model_src = src_cnt;
                return;
            end
            if (rst_after >= 0 && sent >= rst_after) begin
                rst = 1'b1;
                ll_ready = 1'b0;
                ll_write_hold = 1'b0;
                @(posedge clk); #1;
                check1("rst_start", ll_write_start, 1'b0);
                check("rst_size", 32'(ll_write_size), 32'd0);
                check1("rst_strobe", ll_write_strobe, 1'b0);
                check("rst_data", ll_write_data, 32'd0);
                check1("rst_src_strobe", src_strobe, 1'b0);
                check1("rst_xmit_error", xmit_error, 1'b0);
                check1("rst_ready", transport_layer_ready, 1'b0);
                rst = 1'b0;
                ll_ready = 1'b1;
                exp_q.delete(); size_q.delete();
                model_src = src_cnt;
                @(posedge clk); #1;
                check1("post_rst_xmit_error", xmit_error, 1'b0);
                return;
            end
            if (exp_q.size() == 0) break;
            if (hold_pct < 0) ll_write_hold = cyc[0];
            else ll_write_hold = ($urandom_range(99) < hold_pct);
            send_dma_act_stb = dma_mid && (sent == 2);
            @(posedge clk); #1;
            send_dma_act_stb = 1'b0;
            check1("ready_busy", transport_layer_ready, 1'b0);
        end
        ll_write_hold = 1'b0;
        check("frame_remaining", 32'(exp_q.size()), 32'd0);
        check("start_remaining", 32'(size_q.size()), 32'd0);
        check1("ready_wait_fin", transport_layer_ready, 1'b0);
        ll_write_finished = 1'b1;
        @(posedge clk); #1;
        ll_write_finished = 1'b0;
        check1("ready_after_finish", transport_layer_ready, 1'b1);
        exp_q.delete(); size_q.delete();
        model_src = src_cnt;
    endtask

    initial begin
        fld_t f;
        logic [4:0] m;
        int t, len, ea;
        rst = 1'b1; ll_ready = 1'b0; ll_write_hold = 1'b0;
        ll_write_finished = 1'b0; ll_xmit_error = 1'b0;
        drive_strobes(5'b0);
        f = '{default: '0};
        drive_fields(f);
        repeat (3) @(posedge clk);
        #1;
        check1("reset_start", ll_write_start, 1'b0);
        check1("reset_strobe", ll_write_strobe, 1'b0);
        check("reset_data", ll_write_data, 32'd0);
        check1("reset_src_strobe", src_strobe, 1'b0);
        check1("reset_xmit_error", xmit_error, 1'b0);
        check1("reset_ready", transport_layer_ready, 1'b0);
        rst = 1'b0; ll_ready = 1'b1;
        @(posedge clk); #1;

        f = '{default: '0};
        f.st = 8'h50; f.er = 8'h01; f.lba = 48'd1; f.cnt = 16'd1;
        run_frame(5'b00001, f, 0, -1, -1, 1'b0);
        run_frame(5'b10000, rand_fields(), 0, -1, -1, 1'b0);
        run_frame(5'b10000, rand_fields(), -1, -1, -1, 1'b0);
        run_frame(5'b10001, f, 0, -1, -1, 1'b1);
        run_frame(5'b00100, rand_fields(), 0, 2, -1, 1'b0);
        run_frame(5'b10000, rand_fields(), 0, -1, 2, 1'b0);
        f = '{default: '0};
        run_frame(5'b01000, f, 0, -1, -1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(7) == 0) begin
                ll_ready = 1'b0;
                drive_strobes(5'($urandom_range(1, 31)));
                #0 check1("ready_no_link", transport_layer_ready, 1'b0);
                @(posedge clk); #1;
                drive_strobes(5'b0);
                ll_ready = 1'b1;
                @(posedge clk); #1;
            end
            m = 5'($urandom_range(1, 31));
            t = 0;
            while (!m[t]) t++;
            len = (t == 0 || t == 2) ? 5 : (t == 1) ? 2 : (t == 3) ? 1 : DW + 1;
            ea = ($urandom_range(5) == 0) ? $urandom_range(1, len) : -1;
            run_frame(m, rand_fields(), $urandom_range(60), ea, -1, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_xmit_error_count", 32'(exp_xerr), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/faux_hd_transport_tx.md
Name: faux_hd_transport_tx

Overview:
- Device-side transmit transport stage for the simulated SATA hard drive.
- Sits directly downstream of the faux drive command layer. Consumes its send_*_stb strobes plus the D2H/PIO field buses, and serializes the matching device-to-host FIS as 32-bit dwords into the faux link layer's write interface.
- Data FIS payload dwords are pulled from the drive's data source in lockstep with link acceptance.

Parameters:
- DATA_DWORDS, 2048: payload dwords per Data FIS (excludes header); range 1..8191.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- transport_layer_ready  out  1  high = a send strobe will be accepted this cycle
- send_reg_stb  in  1  send Register D2H FIS (34h)
- send_dev_bits_stb  in  1  send Set Device Bits FIS (A1h)
- send_pio_stb  in  1  send PIO Setup FIS (5Fh)
- send_dma_act_stb  in  1  send DMA Activate FIS (39h)
- send_data_stb  in  1  send Data FIS (46h)
- d2h_interrupt, d2h_notification  in  1 each  I and N bits
- d2h_status, d2h_error  in  8 each  status/error bytes
- d2h_port_mult  in  4  port multiplier field
- d2h_device  in  8  device byte
- d2h_lba  in  48  LBA
- d2h_sector_count  in  16  count
- pio_transfer_count  in  16  PIO transfer count
- pio_direction  in  1  PIO D bit
- pio_e_status  in  8  PIO ending status
- src_strobe  out  1  consume one payload dword
- src_data  in  32  payload dword, valid whenever src_strobe is high
- ll_ready  in  1  link idle and able to start a frame
- ll_write_start  out  1  one-cycle frame-start pulse
- ll_write_size  out  24  frame length in dwords, valid with ll_write_start
- ll_write_strobe  out  1  ll_write_data valid and accepted this cycle
- ll_write_data  out  32  FIS dword
- ll_write_hold  in  1  link stall; no strobe this cycle
- ll_write_finished  in  1  frame completed by link
- ll_xmit_error  in  1  link reports frame failure
- xmit_error  out  1  one-cycle pulse on aborted frame

Behaviour:
- Reset values: all outputs 0; state IDLE; latched fields 0. Reset mid-frame aborts immediately without pulsing xmit_error.
- transport_layer_ready = (state==IDLE) && ll_ready. It is combinational and drops the cycle after acceptance.
- Accept: a strobe in cycle N with ready high latches all field inputs and the FIS type, and moves to START at N+1. Strobes while not ready are dropped silently.
- Simultaneous strobes: priority reg > dev_bits > pio > dma_act > data. Only one FIS is sent; the others are dropped.
- Frame lengths in dwords: 34h=5, A1h=2, 5Fh=5, 39h=1, 46h=1+DATA_DWORDS.
- START (1 cycle): ll_write_start=1 and ll_write_size=length, then go to SEND with index=0.
- SEND:
  - Each cycle with !ll_write_hold: ll_write_strobe=1, ll_write_data=dword[index], index++.
  - Data FIS: index>=1 also asserts src_strobe that cycle, and ll_write_data=src_data.
  - After the dword at index length-1 is strobed, go to WAIT_FIN. The index counter is 14 bits.
- WAIT_FIN: on ll_write_finished go to IDLE.
- Error: ll_xmit_error in START, SEND or WAIT_FIN causes a 1-cycle xmit_error pulse the next cycle and a return to IDLE. No strobe is issued in the error cycle.
- Dword layouts (byte0 = bits [7:0]):
  - 34h:
    - DW0={err,status,1'b0,I,2'b0,pm,8'h34}
    - DW1={device,lba[23:0]}
    - DW2={8'h0,lba[47:24]}
    - DW3={16'h0,count}
    - DW4=0
  - A1h:
    - DW0={err,1'b0,status[6:4],1'b0,status[2:0],N,I,2'b0,pm,8'hA1}
    - DW1=0
  - 5Fh:
    - DW0={err,status,1'b0,I,D,1'b0,pm,8'h5F}
    - DW1, DW2 as 34h
    - DW3={e_status,8'h0,count}
    - DW4={16'h0,xfer_count}
  - 39h: DW0={16'h0,4'h0,pm,8'h39}
  - 46h: DW0={16'h0,4'h0,pm,8'h46}, then payload.
- Fields are taken from the latched copies only. Input changes mid-frame have no effect.

Test Plan:
- Register FIS: d2h_status=50h, error=01h, lba=1, count=1, I=0, ll_ready=1; pulse send_reg_stb → ll_write_start with size=5, then 5 strobes 0x01500034, 0x00000001, 0, 0x00000001, 0. Finished → ready high again.
- Data FIS with DATA_DWORDS=4 and src_data incrementing from 0xA0: → size=5, header 0x00000046, payload A0..A3. src_strobe is high exactly 4 cycles, coincident with the payload strobes.
- Hold: same data frame with ll_write_hold high on alternate cycles → no strobe on hold cycles, no src_strobe on hold cycles, payload order preserved.
- Simultaneous send_reg_stb and send_data_stb → only the 34h frame is sent. A send_dma_act_stb pulsed during SEND is dropped; ready stays 0 until finished.
- ll_xmit_error asserted mid-SEND of a PIO frame → xmit_error pulses once, state returns to IDLE, ready=1 the following cycle.
- rst asserted mid-data-frame → all outputs 0 next cycle, no xmit_error. A subsequent 39h frame emits the single dword 0x00000039.
